// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register and register-file write-back driver.
// It also exports the registered write to the forwarding unit and counts retired instructions.
module mem_wb_stage #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              flush,
    input  logic              mem_valid,
    input  logic              mem_RegWrite,
    input  logic              mem_MemtoReg,
    input  logic [4:0]        mem_WriteReg,
    input  logic [DATA_W-1:0] mem_ALUResult,
    input  logic [DATA_W-1:0] mem_ReadData,
    output logic              wb_valid,
    output logic              RegWrite,
    output logic [4:0]        WriteReg,
    output logic [DATA_W-1:0] WriteData,
    output logic              fwd_en,
    output logic [CNT_W-1:0]  retired_count
);

    localparam int unsigned REG_W = 5;

    logic [DATA_W-1:0] writeDataNext;
    logic              regWriteNext;

    // Select the result before the register, and fold the $zero check in before the register too,
    // so that every output comes straight from a flop.
    always_comb begin
        writeDataNext = mem_ALUResult;
        if (mem_MemtoReg) begin
            writeDataNext = mem_ReadData;
        end
        regWriteNext = mem_valid & mem_RegWrite & (mem_WriteReg != REG_W'(0));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wb_valid      <= 1'b0;
            RegWrite      <= 1'b0;
            WriteReg      <= REG_W'(0);
            WriteData     <= DATA_W'(0);
            retired_count <= CNT_W'(0);
        end else if (flush) begin
            wb_valid <= 1'b0;
            RegWrite <= 1'b0;
        end else if (!stall) begin
            wb_valid  <= mem_valid;
            RegWrite  <= regWriteNext;
            WriteReg  <= mem_WriteReg;
            WriteData <= writeDataNext;
            if (mem_valid) begin
                retired_count <= retired_count + CNT_W'(1);
            end
        end
    end

    assign fwd_en = RegWrite;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Bench for mem_wb_stage: directed steps, then random traffic checked against a rule-level model.
// A second instance with a 4-bit counter exercises the counter wrap.
module tb_mem_wb_stage;

    logic        clk = 1'b0;
    logic        reset, stall, flush;
    logic        mem_valid, mem_RegWrite, mem_MemtoReg;
    logic [4:0]  mem_WriteReg;
    logic [31:0] mem_ALUResult, mem_ReadData;

    logic        wb_valid, RegWrite, fwd_en;
    logic [4:0]  WriteReg;
    logic [31:0] WriteData, retired_count;

    logic        sValid, sRegWrite, sFwd;
    logic [4:0]  sWriteReg;
    logic [31:0] sWriteData;
    logic [3:0]  sCount;

    int checks   = 0;
    int failures = 0;

    // Reference state, derived directly from the capture/flush/stall/reset rules
    bit          mValid, mWrite, mKnown;
    int unsigned mReg, mData, mCount;

    always #5 clk = ~clk;

    mem_wb_stage #(.DATA_W(32), .CNT_W(32)) dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .mem_valid(mem_valid), .mem_RegWrite(mem_RegWrite), .mem_MemtoReg(mem_MemtoReg),
        .mem_WriteReg(mem_WriteReg), .mem_ALUResult(mem_ALUResult), .mem_ReadData(mem_ReadData),
        .wb_valid(wb_valid), .RegWrite(RegWrite), .WriteReg(WriteReg), .WriteData(WriteData),
        .fwd_en(fwd_en), .retired_count(retired_count)
    );

    mem_wb_stage #(.DATA_W(32), .CNT_W(4)) dutSmall (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .mem_valid(mem_valid), .mem_RegWrite(mem_RegWrite), .mem_MemtoReg(mem_MemtoReg),
        .mem_WriteReg(mem_WriteReg), .mem_ALUResult(mem_ALUResult), .mem_ReadData(mem_ReadData),
        .wb_valid(sValid), .RegWrite(sRegWrite), .WriteReg(sWriteReg), .WriteData(sWriteData),
        .fwd_en(sFwd), .retired_count(sCount)
    );

    task automatic chk(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic drive(input bit v, input bit rw, input bit m2r, input int unsigned wr,
                         input int unsigned alu, input int unsigned rd);
        mem_valid     = v;
        mem_RegWrite  = rw;
        mem_MemtoReg  = m2r;
        mem_WriteReg  = 5'(wr);
        mem_ALUResult = alu;
        mem_ReadData  = rd;
    endtask

    // Advance one edge, apply the rules to the model, then compare all outputs
    task automatic step(input string tag);
        @(posedge clk);
        if (reset) begin
            mValid = 0; mWrite = 0; mReg = 0; mData = 0; mCount = 0; mKnown = 1;
        end else if (flush) begin
            mValid = 0; mWrite = 0; mKnown = 0;
        end else if (!stall) begin
            mValid = mem_valid;
            mReg   = mem_WriteReg;
            mData  = mem_MemtoReg ? mem_ReadData : mem_ALUResult;
            mWrite = mem_valid && mem_RegWrite && (mem_WriteReg != 0);
            if (mem_valid) mCount = mCount + 1;
            mKnown = 1;
        end
        #1;
        chk({tag, ".wb_valid"}, 64'(wb_valid), 64'(mValid));
        chk({tag, ".RegWrite"}, 64'(RegWrite), 64'(mWrite));
        chk({tag, ".fwd_en"}, 64'(fwd_en), 64'(mWrite));
        chk({tag, ".count"}, 64'(retired_count), 64'(mCount));
        chk({tag, ".count4"}, 64'(sCount), 64'(mCount % 16));
        if (mKnown) begin
            chk({tag, ".WriteReg"}, 64'(WriteReg), 64'(mReg));
            chk({tag, ".WriteData"}, 64'(WriteData), 64'(mData));
        end
    endtask

    initial begin
        mValid = 0; mWrite = 0; mKnown = 0; mReg = 0; mData = 0; mCount = 0;
        reset = 1; stall = 0; flush = 0;
        drive(1, 1, 0, 3, 32'h1111, 32'h2222);
        #1;
        step("reset0");
        step("reset1");
        reset = 0;

        drive(1, 1, 0, 8, 32'h0000_1234, 32'hDEAD_BEEF);
        step("alu");
        drive(1, 1, 1, 9, 32'h0000_0001, 32'hCAFE_F00D);
        step("load");
        drive(1, 1, 1, 0, 32'h0000_0001, 32'hCAFE_F00D);
        step("zero");
        drive(0, 1, 0, 7, 32'h77, 32'h88);
        step("bubble");

        drive(1, 1, 0, 10, 32'h55, 32'h0);
        step("cap10");
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, 1, 11 + i, 32'hA0 + i, 32'hB0 + i);
            step("stall");
        end
        chk("stall.hold_reg", 64'(WriteReg), 64'd10);
        chk("stall.hold_data", 64'(WriteData), 64'h55);
        flush = 1;
        step("stallflush");
        stall = 0; flush = 0;

        // Counter wrap on the 4-bit instance: 16 valid captures return it to its start value
        drive(1, 0, 0, 1, 32'h1, 32'h2);
        for (int i = 0; i < 16; i++) step("wrap");
        chk("wrap.count4_zero", 64'(sCount), 64'((mCount - 16) % 16));

        drive(1, 1, 0, 5, 32'h0000_0AAA, 32'h0);
        step("reg5");
        reset = 1;
        drive(1, 1, 0, 5, 32'h0000_0BBB, 32'h0);
        step("midreset");
        chk("midreset.no_write", 64'(RegWrite), 64'd0);
        reset = 0;
        drive(0, 0, 0, 0, 0, 0);
        step("after_reset");

        for (int i = 0; i < 400; i++) begin
            reset = ($urandom_range(0, 49) == 0);
            flush = ($urandom_range(0, 9) == 0);
            stall = ($urandom_range(0, 5) == 0);
            drive(1'($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom),
                  $urandom_range(0, 31), $urandom, $urandom);
            step("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
